cache_request_gen: RTL

Trace-driven request initiator for the tag-only cache lookup/update block. It replays a stored trace of 32-bit byte addresses and splits each address into tag and set index. For each address it drives one find request and waits for the lookup result, plus the fill completion on a miss. It accumulates request, hit, miss and latency statistics for the simulator top level.

---
 rtl/cache_request_gen.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cache_request_gen.sv
// Trace-driven request initiator for the tag-only cache lookup/update block.
// Replays stored byte addresses, issues one find request per address, waits
// for the lookup (and the fill on a miss), and keeps request/hit/miss/latency
// statistics for the simulator top level.
module cache_request_gen #(
  parameter int way             = 1,
  parameter int block_size_byte = 16,
  parameter int cache_size_byte = 32768,
  parameter int trace_depth     = 1024,
  parameter int timeout_cycles  = 255,
  localparam int block_offset_index = $clog2(block_size_byte),
  localparam int num_set            = cache_size_byte / (block_size_byte * way),
  localparam int set_index          = $clog2(num_set),
  localparam int tag_width          = 32 - set_index - block_offset_index,
  localparam int addr_width         = $clog2(trace_depth)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [addr_width:0]     trace_len,
  input  logic                    trace_wr_en,
  input  logic [addr_width-1:0]   trace_wr_addr,
  input  logic [31:0]             trace_wr_data,
  output logic                    find_start,
  output logic [set_index-1:0]    index,
  output logic [28:0]             tag,
  input  logic                    done,
  input  logic                    found_in_cache,
  input  logic                    updated,
  output logic                    busy,
  output logic                    finished,
  output logic                    error,
  output logic [31:0]             req_count,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count,
  output logic [31:0]             total_latency
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ISSUE,
    WAIT_DONE,
    WAIT_UPD,
    NEXT,
    FINISH
  } state_t;

  state_t state;
  state_t state_next;

  // Trace storage; contents survive reset.
  logic [31:0] trace_mem [trace_depth];
  logic [31:0] rd_data;

  logic [addr_width:0] ptr;
  logic [addr_width:0] ptr_inc;
  logic [addr_width:0] len_q;
  logic [31:0]         wait_cnt;

  logic                 start_accept;
  logic                 in_wait;
  logic                 wait_expired;
  logic                 timeout_exit;
  logic                 done_accept;
  logic [28:0]          tag_ext;
  logic [set_index-1:0] index_ext;

  assign ptr_inc = ptr + 1'b1;

  // Cycle in which the wait counter would reach the limit; the awaited
  // strobe takes priority when it arrives in this same cycle.
  assign wait_expired = (wait_cnt + 32'd1) >= 32'(timeout_cycles);

  // Split the registered trace word into tag and set index.  Tag is
  // zero-extended because the responder's tag port is a fixed 29 bits.
  assign tag_ext   = 29'(rd_data >> (block_offset_index + set_index));
  assign index_ext = set_index'(rd_data >> block_offset_index);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state outputs.
  always_comb begin
    state_next   = state;
    find_start   = 1'b0;
    busy         = 1'b1;
    finished     = 1'b0;
    start_accept = 1'b0;
    in_wait      = 1'b0;
    timeout_exit = 1'b0;
    done_accept  = 1'b0;
    case (state)
      IDLE, FINISH: begin
        busy     = 1'b0;
        finished = (state == FINISH);
        if (start) begin
          start_accept = 1'b1;
          state_next   = (trace_len == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        state_next = ISSUE;
      end
      ISSUE: begin
        find_start = 1'b1;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        in_wait = 1'b1;
        if (done) begin
          done_accept = 1'b1;
          state_next  = found_in_cache ? NEXT : WAIT_UPD;
        end else if (wait_expired) begin
          timeout_exit = 1'b1;
          state_next   = FINISH;
        end
      end
      WAIT_UPD: begin
        in_wait = 1'b1;
        if (updated) begin
          state_next = NEXT;
        end else if (wait_expired) begin
          timeout_exit = 1'b1;
          state_next   = FINISH;
        end
      end
      NEXT: begin
        state_next = (ptr_inc == len_q) ? FINISH : FETCH;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Trace memory: writes are locked out during a replay; read is registered.
  always_ff @(posedge clk) begin
    if (trace_wr_en && !busy) begin
      trace_mem[trace_wr_addr] <= trace_wr_data;
    end
    rd_data <= trace_mem[ptr[addr_width-1:0]];
  end

  // Replay pointer and the trace length captured at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      len_q <= '0;
    end else if (start_accept) begin
      ptr   <= '0;
      len_q <= trace_len;
    end else if (state == NEXT) begin
      ptr   <= ptr_inc;
    end
  end

  // Tag/index are captured in LOAD and held through lookup and fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag   <= '0;
      index <= '0;
    end else if (state == LOAD) begin
      tag   <= tag_ext;
      index <= index_ext;
    end
  end

  // Per-request wait counter, cleared as the request is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (in_wait) begin
      wait_cnt <= wait_cnt + 32'd1;
    end
  end

  // Run statistics and the sticky timeout flag; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_count     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      total_latency <= '0;
      error         <= 1'b0;
    end else if (start_accept) begin
      req_count     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      total_latency <= '0;
      error         <= 1'b0;
    end else begin
      if (in_wait) begin
        total_latency <= total_latency + 32'd1;
      end
      if (done_accept) begin
        req_count <= req_count + 32'd1;
        if (found_in_cache) begin
          hit_count <= hit_count + 32'd1;
        end else begin
          miss_count <= miss_count + 32'd1;
        end
      end
      if (timeout_exit) begin
        error <= 1'b1;
      end
    end
  end

endmodule
